// File: rtl/aud_echo.sv
// Single-tap echo: circular sample buffer, attenuated delayed tap mixed into the dry path.
// Define ECHO_FEEDBACK_EN to write the mixed sum back to the buffer for a decaying echo.
module aud_echo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic [DATA_WIDTH-1:0] iDATA,
    input  logic                  iSTB,
    input  logic [ADDR_WIDTH-1:0] iDELAY,
    input  logic [1:0]            iGAIN,
    output logic [DATA_WIDTH-1:0] oDATA,
    output logic                  oVALID,
    output logic                  oBUSY,
    output logic                  oOVF
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RD, MIX, WR} state_t;

    state_t state;
    state_t state_nxt;

    logic        [DATA_WIDTH-1:0] mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] dry;
    logic signed [DATA_WIDTH-1:0] q;
    logic signed [DATA_WIDTH-1:0] wet;
    logic signed [DATA_WIDTH-1:0] sum_sat;
    logic        [DATA_WIDTH:0]   sum;
    logic        [DATA_WIDTH-1:0] wdata;
    logic        [ADDR_WIDTH-1:0] delay;
    logic        [ADDR_WIDTH-1:0] wr_ptr;
    logic        [ADDR_WIDTH-1:0] fill;
    logic        [ADDR_WIDTH-1:0] rd_addr;
    logic        [1:0]            gain;
    logic        [2:0]            shamt;

    assign rd_addr = wr_ptr - delay;
    assign shamt   = {1'b0, gain} + 3'd1;
    assign oBUSY   = (state != IDLE);

`ifdef ECHO_FEEDBACK_EN
    assign wdata = oDATA;
`else
    assign wdata = dry;
`endif

    // Buffer has no reset; the fill gate keeps stale words off the output.
    always_ff @(posedge iCLK_18_4) begin
        if (state == WR) begin
            mem[wr_ptr] <= wdata;
        end
        if (state == RD) begin
            q <= mem[rd_addr];
        end
    end

    always_comb begin
        wet = '0;
        if (delay != '0 && fill >= delay) begin
            wet = q >>> shamt;
        end
    end

    assign sum = {dry[DATA_WIDTH-1], dry} + {wet[DATA_WIDTH-1], wet};

    always_comb begin
        sum_sat = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            sum_sat = sum[DATA_WIDTH]
                    ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (iSTB) state_nxt = RD;
            RD:   state_nxt = MIX;
            MIX:  state_nxt = WR;
            WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            dry    <= '0;
            delay  <= '0;
            gain   <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            oDATA  <= '0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            if (iSTB && state == IDLE) begin
                dry   <= iDATA;
                delay <= iDELAY;
                gain  <= iGAIN;
            end
            if (iSTB && state != IDLE) begin
                oOVF <= 1'b1;
            end
            // Output is registered on entry to WR so it is valid during WR.
            if (state == MIX) begin
                oDATA  <= sum_sat;
                oVALID <= 1'b1;
            end
            if (state == WR) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (fill != '1) begin
                    fill <= fill + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aud_echo.sv
// Scoreboard bench for aud_echo with a small buffer so pointer wrap is reached.
module tb_aud_echo;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          stb;
    logic [AW-1:0] delay;
    logic [1:0]    gain;
    logic [DW-1:0] dout;
    logic          valid;
    logic          busy;
    logic          ovf;

    int vectors;
    int miscompares;
    int nvalid;
    int exp_q[$];

    aud_echo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .iCLK_18_4(clk),
        .iRST_N   (rst_n),
        .iDATA    (data),
        .iSTB     (stb),
        .iDELAY   (delay),
        .iGAIN    (gain),
        .oDATA    (dout),
        .oVALID   (valid),
        .oBUSY    (busy),
        .oOVF     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s got %0d need %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            nvalid++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid got %0d need none", $signed(dout));
            end else begin
                check("scoreboard", int'($signed(dout)), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stb   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobe(input int v, input int d, input int g);
        @(negedge clk);
        data  = DW'(v);
        delay = AW'(d);
        gain  = 2'(g);
        stb   = 1'b1;
        @(negedge clk);
        stb   = 1'b0;
    endtask

    task automatic send(input int v, input int d, input int g, input int e);
        exp_q.push_back(e);
        strobe(v, d, g);
        repeat (5) @(negedge clk);
    endtask

    int imp_in[$]  = '{1000, 0, 0, 0, 0, 0, 0};
`ifdef ECHO_FEEDBACK_EN
    int imp_exp[$] = '{1000, 0, 500, 0, 250, 0, 125};
`else
    int imp_exp[$] = '{1000, 0, 500, 0, 0, 0, 0};
`endif
    int w[21];
    int n0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        nvalid      = 0;
        rst_n = 1'b0;
        stb   = 1'b0;
        data  = '0;
        delay = '0;
        gain  = '0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(dout), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // Latency and pulse shape, delay 0.
        exp_q.push_back(100);
        strobe(100, 0, 0);
        check("lat_rd_busy", int'(busy), 1);
        check("lat_rd_valid", int'(valid), 0);
        @(negedge clk);
        check("lat_mix_valid", int'(valid), 0);
        @(negedge clk);
        check("lat_wr_valid", int'(valid), 1);
        check("lat_wr_data", int'($signed(dout)), 100);
        check("lat_wr_busy", int'(busy), 1);
        @(negedge clk);
        check("lat_post_valid", int'(valid), 0);
        check("lat_post_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Impulse, delay 2, gain 0.
        do_reset();
        foreach (imp_in[i]) send(imp_in[i], 2, 0, imp_exp[i]);

        // Saturation high then low, delay 1.
        do_reset();
        send(32767, 1, 0, 32767);
        send(32767, 1, 0, 32767);
        do_reset();
        send(-32768, 1, 0, -32768);
        send(-32768, 1, 0, -32768);
        send(0, 1, 0, -16384);

        // Ramp through buffer wrap with fill gate, delay 7, gain 1.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            int e;
            e = k + ((k > 7) ? (w[k-7] >>> 2) : 0);
`ifdef ECHO_FEEDBACK_EN
            w[k] = e;
`else
            w[k] = k;
`endif
            send(k, 7, 1, e);
        end

        // Strobe two cycles after an accepted one is dropped.
        do_reset();
        check("ovf_clear", int'(ovf), 0);
        n0 = nvalid;
        exp_q.push_back(55);
        strobe(55, 0, 0);
        strobe(66, 0, 0);
        repeat (8) @(negedge clk);
        check("ovf_set", int'(ovf), 1);
        check("ovf_one_valid", nvalid - n0, 1);
        repeat (10) @(negedge clk);
        check("ovf_sticky", int'(ovf), 1);

        // Strobe landing in the WR cycle is dropped too.
        do_reset();
        n0 = nvalid;
        exp_q.push_back(11);
        strobe(11, 0, 0);
        @(negedge clk);
        strobe(22, 0, 0);
        repeat (6) @(negedge clk);
        check("wr_ovf_set", int'(ovf), 1);
        check("wr_one_valid", nvalid - n0, 1);
        send(33, 0, 0, 33);

        // Reset during MIX: no output, fill cleared.
        do_reset();
        send(500, 1, 0, 500);
        n0 = nvalid;
        strobe(600, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("mid_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_valid", nvalid - n0, 0);
        send(77, 1, 0, 77);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running need finished");
        $fatal(1, "timeout");
    end

endmodule
